// File: rtl/rgb_pwm_gen.sv
// Three-channel bus-programmed PWM engine with double-buffered duties and an
// optional triangular breathing envelope scaling all channels.
module rgb_pwm_gen #(
   parameter int PSC_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       we,
   input  logic [3:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic [2:0] pwm,
   output logic       frame
);

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } breath_t;

   // Upper byte of the 8x8 unsigned product: duty scaled by envelope level.
   function automatic logic [7:0] scale_duty(input logic [7:0] duty, input logic [7:0] lvl);
      logic [15:0] prod;
      prod = {8'd0, duty} * {8'd0, lvl};
      return prod[15:8];
   endfunction

   logic             wr_en;
   logic             rd_en;

   logic [2:0][7:0]  duty_stg;
   logic [2:0][7:0]  duty_act;
   logic [PSC_W-1:0] psc;
   logic             en;
   logic             breathe;
   logic [7:0]       rate;

   logic [PSC_W-1:0] psc_cnt;
   logic [7:0]       cnt_p0;
   logic             tick;
   logic             frame_end;

   breath_t          state;
   breath_t          state_nxt;
   logic [7:0]       level;
   logic [7:0]       level_nxt;
   logic [7:0]       div;
   logic [7:0]       div_nxt;

   logic [2:0][7:0]  eff;
   logic [2:0]       pwm_p1;
   logic             frame_p1;
   logic [7:0]       rd_data;

   assign wr_en     = cs & we;
   assign rd_en     = cs & ~we;
   assign tick      = en && (psc_cnt == psc);
   assign frame_end = tick && (cnt_p0 == 8'hFF);

   // Register file writes
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_stg <= '0;
         psc      <= '0;
         en       <= 1'b0;
         breathe  <= 1'b0;
         rate     <= 8'd0;
      end else if (wr_en) begin
         case (addr)
            4'd0:    duty_stg[0] <= din;
            4'd1:    duty_stg[1] <= din;
            4'd2:    duty_stg[2] <= din;
            4'd3:    psc         <= PSC_W'(din);
            4'd4: begin
               en      <= din[0];
               breathe <= din[1];
            end
            4'd5:    rate        <= din;
            default: ;
         endcase
      end
   end

   // Stage 0: prescaler and frame counter; an unmatched count simply wraps
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         psc_cnt <= '0;
         cnt_p0  <= 8'd0;
      end else if (tick) begin
         psc_cnt <= '0;
         cnt_p0  <= cnt_p0 + 8'd1;
      end else begin
         psc_cnt <= psc_cnt + PSC_W'(1);
      end
   end

   // Active duties swap only at a frame end, so a same-edge write lands next frame
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_act <= '0;
      end else if (frame_end) begin
         duty_act <= duty_stg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= UP;
         level <= 8'd0;
         div   <= 8'd0;
      end else begin
         state <= state_nxt;
         level <= level_nxt;
         div   <= div_nxt;
      end
   end

   // Turn around on the step that lands on an endpoint so level never wraps
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      div_nxt   = div;
      if (frame_end && breathe) begin
         if (div == rate) begin
            div_nxt = 8'd0;
            case (state)
               UP: begin
                  level_nxt = level + 8'd1;
                  if (level == 8'hFE) state_nxt = DOWN;
               end
               DOWN: begin
                  level_nxt = level - 8'd1;
                  if (level == 8'h01) state_nxt = UP;
               end
               default: state_nxt = UP;
            endcase
         end else begin
            div_nxt = div + 8'd1;
         end
      end
   end

   always_comb begin
      for (int n = 0; n < 3; n++) begin
         eff[n] = breathe ? scale_duty(duty_act[n], level) : duty_act[n];
      end
   end

   // Stage 1: registered compare outputs, one clock behind the counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_p1   <= 3'b000;
         frame_p1 <= 1'b0;
      end else begin
         for (int n = 0; n < 3; n++) begin
            pwm_p1[n] <= en && (cnt_p0 < eff[n]);
         end
         frame_p1 <= frame_end;
      end
   end

   assign pwm   = pwm_p1;
   assign frame = frame_p1;

   always_comb begin
      rd_data = 8'd0;
      case (addr)
         4'd0:    rd_data = duty_stg[0];
         4'd1:    rd_data = duty_stg[1];
         4'd2:    rd_data = duty_stg[2];
         4'd3:    rd_data = 8'(psc);
         4'd4:    rd_data = {6'd0, breathe, en};
         4'd5:    rd_data = rate;
         4'd6:    rd_data = level;
         4'd7:    rd_data = {6'd0, en, state == DOWN};
         default: rd_data = 8'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= 8'd0;
      end else if (rd_en) begin
         dout <= rd_data;
      end
   end

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen: register access, duty timing, buffering,
// prescale, breathing ramp, disable/re-enable and mid-run reset.
module tb_rgb_pwm_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs;
   logic       we;
   logic [3:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic [2:0] pwm;
   logic       frame;

   int checks = 0;
   int errors = 0;

   rgb_pwm_gen #(.PSC_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs),
      .we    (we),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .pwm   (pwm),
      .frame (frame)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      step();
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; addr = a;
      step();
      d = dout;
      cs = 1'b0;
   endtask

   // Returns right after the sample where frame is seen high.
   task automatic wait_frame(output logic [2:0] seen);
      logic ok;
      ok   = 1'b0;
      seen = 3'b000;
      for (int i = 0; i < 4000; i++) begin
         step();
         seen = seen | pwm;
         if (frame === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check("frame_wait", ok, 1);
   endtask

   task automatic count_frame(input int len, output int h0, output int h1, output int h2);
      h0 = 0; h1 = 0; h2 = 0;
      for (int i = 0; i < len; i++) begin
         step();
         h0 += int'(pwm[0]);
         h1 += int'(pwm[1]);
         h2 += int'(pwm[2]);
      end
   endtask

   initial begin
      logic [7:0] rv;
      logic [2:0] seen;
      int         h0, h1, h2;
      logic       at_pulse;

      rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 4'd0; din = 8'd0;
      repeat (3) step();
      rst = 1'b0;
      check("reset_pwm", pwm, 0);
      check("reset_frame", frame, 0);
      check("reset_dout", dout, 0);
      for (int a = 0; a < 16; a++) begin
         rd(4'(a), rv);
         check($sformatf("reset_read_%0d", a), rv, 0);
      end
      check("reset_pwm_after_reads", pwm, 0);

      // Red at 25%: first frame dark because active duties start at 0
      wr(4'd3, 8'h00);
      wr(4'd0, 8'h40);
      wr(4'd4, 8'h01);
      wait_frame(seen);
      check("first_frame_dark", seen, 0);
      count_frame(256, h0, h1, h2);
      check("r40_high", h0, 64);
      check("r40_g_low", h1, 0);
      check("frame_period_a", frame, 1);
      count_frame(256, h0, h1, h2);
      check("r40_high_2", h0, 64);
      check("frame_period_b", frame, 1);

      // Green buffering: mid-frame write and write on the frame-end edge
      wr(4'd1, 8'h80);
      wait_frame(seen);
      h1 = 0;
      for (int i = 0; i < 256; i++) begin
         if (i == 100) begin
            cs = 1'b1; we = 1'b1; addr = 4'd1; din = 8'h10;
         end else begin
            cs = 1'b0; we = 1'b0;
         end
         step();
         h1 += int'(pwm[1]);
      end
      cs = 1'b0; we = 1'b0;
      check("g80_kept_mid_write", h1, 128);
      check("frame_period_c", frame, 1);
      count_frame(256, h0, h1, h2);
      check("g10_next_frame", h1, 16);
      check("r40_still", h0, 64);
      h1 = 0;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) begin
            cs = 1'b1; we = 1'b1; addr = 4'd1; din = 8'h30;
         end else begin
            cs = 1'b0; we = 1'b0;
         end
         step();
         h1 += int'(pwm[1]);
      end
      cs = 1'b0; we = 1'b0;
      check("g10_before_edge_write", h1, 16);
      check("frame_on_edge_write", frame, 1);
      count_frame(256, h0, h1, h2);
      check("edge_write_not_captured", h1, 16);
      count_frame(256, h0, h1, h2);
      check("edge_write_next_frame", h1, 48);

      // Prescale by 4, blue at full scale then zero
      wr(4'd3, 8'h03);
      wr(4'd2, 8'hFF);
      wait_frame(seen);
      count_frame(1024, h0, h1, h2);
      check("psc3_b_ff", h2, 1020);
      check("psc3_r40", h0, 256);
      check("psc3_g30", h1, 192);
      check("psc3_frame", frame, 1);
      wr(4'd2, 8'h00);
      wait_frame(seen);
      count_frame(1024, h0, h1, h2);
      check("psc3_b_zero", h2, 0);

      // Breathing ramp up to the top turn
      wr(4'd3, 8'h00);
      wr(4'd5, 8'h00);
      wr(4'd0, 8'hFF);
      wr(4'd4, 8'h03);
      for (int k = 1; k <= 3; k++) begin
         wait_frame(seen);
         rd(4'd6, rv);
         check($sformatf("level_%0d", k), rv, k);
      end
      at_pulse = 1'b0;
      for (int k = 4; k <= 255; k++) begin
         if (!at_pulse) wait_frame(seen);
         at_pulse = 1'b0;
         if (k == 128) begin
            count_frame(256, h0, h1, h2);
            check("level80_r_high", h0, 127);
            check("level80_frame", frame, 1);
            at_pulse = 1'b1;
         end
      end
      rd(4'd6, rv);
      check("level_top", rv, 255);
      rd(4'd7, rv);
      check("status_down", rv, 8'h03);
      wait_frame(seen);
      rd(4'd6, rv);
      check("level_254", rv, 254);
      wait_frame(seen);
      rd(4'd6, rv);
      check("level_253", rv, 253);
      rd(4'd7, rv);
      check("status_still_down", rv, 8'h03);

      // Disable mid-frame, then re-enable without breathing
      repeat (50) step();
      wr(4'd4, 8'h00);
      step();
      check("disable_pwm_low", pwm, 0);
      rd(4'd6, rv);
      check("disable_level_hold", rv, 253);
      rd(4'd7, rv);
      check("disable_status", rv, 8'h01);
      repeat (300) step();
      check("disabled_no_frame", frame, 0);
      check("disabled_pwm_low", pwm, 0);
      wr(4'd4, 8'h01);
      h0 = 0;
      for (int i = 1; i <= 256; i++) begin
         step();
         h0 += int'(pwm[0]);
         if (i == 255) check("reenable_no_early_frame", frame, 0);
      end
      check("reenable_frame_at_256", frame, 1);
      check("reenable_r_ff", h0, 255);
      rd(4'd6, rv);
      check("level_hold_no_breathe", rv, 253);

      // Reset while running
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrun_reset_pwm", pwm, 0);
      check("midrun_reset_frame", frame, 0);
      rd(4'd6, rv);
      check("midrun_reset_level", rv, 0);
      rd(4'd4, rv);
      check("midrun_reset_ctrl", rv, 0);
      step();
      check("midrun_reset_pwm_stays", pwm, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
